// File: rtl/csr_commit_seq_pkg.sv
// rtl/csr_commit_seq_pkg.sv - CSR numbers, field masks and sequencer state encoding
package csr_commit_seq_pkg;

  localparam logic [13:0] CSR_CRMD   = 14'h0;
  localparam logic [13:0] CSR_PRMD   = 14'h1;
  localparam logic [13:0] CSR_ESTAT  = 14'h5;
  localparam logic [13:0] CSR_ERA    = 14'h6;
  localparam logic [13:0] CSR_BADV   = 14'h7;
  localparam logic [13:0] CSR_EENTRY = 14'hC;

  localparam logic [31:0] DEF_PLVIE_MASK = 32'h0000_0007;
  localparam logic [31:0] DEF_ESTAT_MASK = 32'h7FFF_0000;
  localparam logic [31:0] MASK_ALL       = 32'hFFFF_FFFF;

  typedef enum logic [3:0] {
    ST_IDLE         = 4'd0,
    ST_EX_RD_CRMD   = 4'd1,
    ST_EX_WR_PRMD   = 4'd2,
    ST_EX_WR_CRMD   = 4'd3,
    ST_EX_WR_ERA    = 4'd4,
    ST_EX_WR_ESTAT  = 4'd5,
    ST_EX_WR_BADV   = 4'd6,
    ST_EX_RD_EENTRY = 4'd7,
    ST_ER_RD_PRMD   = 4'd8,
    ST_ER_WR_CRMD   = 4'd9,
    ST_ER_RD_ERA    = 4'd10,
    ST_FLUSH        = 4'd11
  } seq_state_t;

endpackage

// File: rtl/csr_commit_seq.sv
// rtl/csr_commit_seq.sv - shares the CSR port between WB accesses and exception/ertn commit sequences
module csr_commit_seq
  import csr_commit_seq_pkg::*;
#(
  parameter logic [31:0] PLVIE_MASK = DEF_PLVIE_MASK,
  parameter logic [31:0] ESTAT_MASK = DEF_ESTAT_MASK
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_csr_req,
  input  logic [13:0] wb_csr_num,
  input  logic        wb_csr_we,
  input  logic [31:0] wb_csr_wmask,
  input  logic [31:0] wb_csr_wvalue,
  output logic        wb_csr_gnt,
  output logic [31:0] wb_csr_rvalue,
  input  logic        wb_ex,
  input  logic [5:0]  wb_ecode,
  input  logic [8:0]  wb_esubcode,
  input  logic [31:0] wb_ex_pc,
  input  logic [31:0] wb_vaddr,
  input  logic        wb_badv_en,
  input  logic        ertn_req,
  output logic        csr_re,
  output logic [13:0] csr_num,
  input  logic [31:0] csr_rvalue,
  output logic        csr_we,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wvalue,
  output logic        busy,
  output logic        flush_valid,
  output logic [31:0] flush_target
);

  seq_state_t  r_state;
  seq_state_t  w_state_nxt;
  logic [5:0]  r_ecode;
  logic [8:0]  r_esubcode;
  logic [31:0] r_pc;
  logic [31:0] r_vaddr;
  logic        r_badv_en;
  logic [31:0] r_mode;
  logic [31:0] r_target;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // r_mode holds the PLV/IE field in flight: CRMD->PRMD on exception, PRMD->CRMD on ertn
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_ecode    <= '0;
      r_esubcode <= '0;
      r_pc       <= '0;
      r_vaddr    <= '0;
      r_badv_en  <= 1'b0;
      r_mode     <= '0;
      r_target   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (wb_ex) begin
            r_ecode    <= wb_ecode;
            r_esubcode <= wb_esubcode;
            r_pc       <= wb_ex_pc;
            r_vaddr    <= wb_vaddr;
            r_badv_en  <= wb_badv_en;
          end
        end
        ST_EX_RD_CRMD, ST_ER_RD_PRMD: r_mode   <= csr_rvalue & PLVIE_MASK;
        ST_EX_RD_EENTRY, ST_ER_RD_ERA: r_target <= csr_rvalue;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    csr_re        = 1'b0;
    csr_we        = 1'b0;
    csr_num       = '0;
    csr_wmask     = '0;
    csr_wvalue    = '0;
    wb_csr_gnt    = 1'b0;
    wb_csr_rvalue = '0;
    busy          = 1'b1;
    flush_valid   = 1'b0;
    flush_target  = '0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (wb_ex) begin
          w_state_nxt = ST_EX_RD_CRMD;
        end else if (ertn_req) begin
          w_state_nxt = ST_ER_RD_PRMD;
        end else if (wb_csr_req) begin
          csr_re        = 1'b1;
          csr_we        = wb_csr_we;
          csr_num       = wb_csr_num;
          csr_wmask     = wb_csr_wmask;
          csr_wvalue    = wb_csr_wvalue;
          wb_csr_gnt    = 1'b1;
          wb_csr_rvalue = csr_rvalue;
        end
      end
      ST_EX_RD_CRMD: begin
        csr_re      = 1'b1;
        csr_num     = CSR_CRMD;
        w_state_nxt = ST_EX_WR_PRMD;
      end
      ST_EX_WR_PRMD: begin
        csr_we      = 1'b1;
        csr_num     = CSR_PRMD;
        csr_wmask   = PLVIE_MASK;
        csr_wvalue  = r_mode;
        w_state_nxt = ST_EX_WR_CRMD;
      end
      ST_EX_WR_CRMD: begin
        csr_we      = 1'b1;
        csr_num     = CSR_CRMD;
        csr_wmask   = PLVIE_MASK;
        w_state_nxt = ST_EX_WR_ERA;
      end
      ST_EX_WR_ERA: begin
        csr_we      = 1'b1;
        csr_num     = CSR_ERA;
        csr_wmask   = MASK_ALL;
        csr_wvalue  = r_pc;
        w_state_nxt = ST_EX_WR_ESTAT;
      end
      ST_EX_WR_ESTAT: begin
        csr_we      = 1'b1;
        csr_num     = CSR_ESTAT;
        csr_wmask   = ESTAT_MASK;
        csr_wvalue  = {1'b0, r_esubcode, r_ecode, 16'b0};
        w_state_nxt = r_badv_en ? ST_EX_WR_BADV : ST_EX_RD_EENTRY;
      end
      ST_EX_WR_BADV: begin
        csr_we      = 1'b1;
        csr_num     = CSR_BADV;
        csr_wmask   = MASK_ALL;
        csr_wvalue  = r_vaddr;
        w_state_nxt = ST_EX_RD_EENTRY;
      end
      ST_EX_RD_EENTRY: begin
        csr_re      = 1'b1;
        csr_num     = CSR_EENTRY;
        w_state_nxt = ST_FLUSH;
      end
      ST_ER_RD_PRMD: begin
        csr_re      = 1'b1;
        csr_num     = CSR_PRMD;
        w_state_nxt = ST_ER_WR_CRMD;
      end
      ST_ER_WR_CRMD: begin
        csr_we      = 1'b1;
        csr_num     = CSR_CRMD;
        csr_wmask   = PLVIE_MASK;
        csr_wvalue  = r_mode;
        w_state_nxt = ST_ER_RD_ERA;
      end
      ST_ER_RD_ERA: begin
        csr_re      = 1'b1;
        csr_num     = CSR_ERA;
        w_state_nxt = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_valid  = 1'b1;
        flush_target = r_target;
        w_state_nxt  = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_csr_commit_seq.sv
// tb/tb_csr_commit_seq.sv - scoreboard bench for csr_commit_seq against a behavioural CSR file
module tb_csr_commit_seq;

  logic        clk;
  logic        resetn;
  logic        wb_csr_req;
  logic [13:0] wb_csr_num;
  logic        wb_csr_we;
  logic [31:0] wb_csr_wmask;
  logic [31:0] wb_csr_wvalue;
  logic        wb_csr_gnt;
  logic [31:0] wb_csr_rvalue;
  logic        wb_ex;
  logic [5:0]  wb_ecode;
  logic [8:0]  wb_esubcode;
  logic [31:0] wb_ex_pc;
  logic [31:0] wb_vaddr;
  logic        wb_badv_en;
  logic        ertn_req;
  logic        csr_re;
  logic [13:0] csr_num;
  logic [31:0] csr_rvalue;
  logic        csr_we;
  logic [31:0] csr_wmask;
  logic [31:0] csr_wvalue;
  logic        busy;
  logic        flush_valid;
  logic [31:0] flush_target;

  csr_commit_seq dut (
    .clk(clk), .resetn(resetn),
    .wb_csr_req(wb_csr_req), .wb_csr_num(wb_csr_num), .wb_csr_we(wb_csr_we),
    .wb_csr_wmask(wb_csr_wmask), .wb_csr_wvalue(wb_csr_wvalue),
    .wb_csr_gnt(wb_csr_gnt), .wb_csr_rvalue(wb_csr_rvalue),
    .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
    .wb_ex_pc(wb_ex_pc), .wb_vaddr(wb_vaddr), .wb_badv_en(wb_badv_en),
    .ertn_req(ertn_req),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue),
    .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
    .busy(busy), .flush_valid(flush_valid), .flush_target(flush_target)
  );

  typedef struct {
    int          cyc;
    bit          is_flush;
    logic [13:0] num;
    logic [31:0] mask;
    logic [31:0] val;
  } ev_t;

  ev_t         exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  int          c0;
  logic [31:0] mem [0:63];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign csr_rvalue = mem[csr_num[5:0]];
  always @(posedge clk) begin
    if (csr_we) mem[csr_num[5:0]] = (mem[csr_num[5:0]] & ~csr_wmask) | (csr_wvalue & csr_wmask);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_wr(input int at, input logic [13:0] num, input logic [31:0] mask, input logic [31:0] val);
    ev_t e;
    e.cyc = at; e.is_flush = 1'b0; e.num = num; e.mask = mask; e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic push_flush(input int at, input logic [31:0] target);
    ev_t e;
    e.cyc = at; e.is_flush = 1'b1; e.num = '0; e.mask = '0; e.val = target;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (csr_we || flush_valid) begin
      if (exp_q.size() == 0) begin
        check("spurious_event", {30'b0, csr_we, flush_valid}, 32'h0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        check("ev_cycle", cyc - c0, e.cyc - c0);
        check("ev_kind", {31'b0, flush_valid}, {31'b0, e.is_flush});
        if (e.is_flush) begin
          check("flush_target", flush_target, e.val);
        end else begin
          check("wr_num", {18'b0, csr_num}, {18'b0, e.num});
          check("wr_mask", csr_wmask, e.mask);
          check("wr_value", csr_wvalue, e.val);
        end
      end
    end
  end

  task automatic idle_inputs();
    wb_csr_req = 0; wb_csr_num = '0; wb_csr_we = 0; wb_csr_wmask = '0; wb_csr_wvalue = '0;
    wb_ex = 0; wb_ecode = '0; wb_esubcode = '0; wb_ex_pc = '0; wb_vaddr = '0; wb_badv_en = 0;
    ertn_req = 0;
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({tag, "_done"}, {31'b0, busy}, 32'h0);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
  endtask

  task automatic drive_ex(input logic [5:0] ec, input logic [8:0] esc, input logic [31:0] pc,
                          input logic [31:0] va, input logic ben);
    wb_ex = 1; wb_ecode = ec; wb_esubcode = esc; wb_ex_pc = pc; wb_vaddr = va; wb_badv_en = ben;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[12] = 32'h1C00_8000;
    mem[7]  = 32'hDEAD_BEEF;
    mem[0]  = 32'h0000_0007;
    idle_inputs();
    resetn = 0;
    c0 = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_csr_re", {31'b0, csr_re}, 0);
    check("rst_csr_we", {31'b0, csr_we}, 0);
    check("rst_csr_num", {18'b0, csr_num}, 0);
    check("rst_csr_wmask", csr_wmask, 0);
    check("rst_csr_wvalue", csr_wvalue, 0);
    check("rst_flush_valid", {31'b0, flush_valid}, 0);
    check("rst_flush_target", flush_target, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_rvalue", wb_csr_rvalue, 0);
    check("rst_gnt", {31'b0, wb_csr_gnt}, 0);
    @(posedge clk); #1;
    resetn = 1;
    @(posedge clk); #1;

    // WB csrwr passes through in the same cycle
    c0 = cyc;
    wb_csr_req = 1; wb_csr_we = 1; wb_csr_num = 14'h30; wb_csr_wmask = 32'hFFFF_FFFF; wb_csr_wvalue = 32'h1234;
    push_wr(c0, 14'h30, 32'hFFFF_FFFF, 32'h1234);
    #1;
    check("wb_gnt", {31'b0, wb_csr_gnt}, 1);
    check("wb_busy", {31'b0, busy}, 0);
    check("wb_csr_re", {31'b0, csr_re}, 1);
    @(posedge clk); #1;
    idle_inputs();
    check("wb_mem30", mem[48], 32'h1234);
    wb_csr_req = 1; wb_csr_we = 0; wb_csr_num = 14'h30;
    #1;
    check("wb_rvalue", wb_csr_rvalue, 32'h1234);
    @(posedge clk); #1;
    idle_inputs();
    check("wb_queue_empty", exp_q.size(), 0);

    // exception without BADV
    c0 = cyc;
    drive_ex(6'hB, 9'h0, 32'h1C00_0100, 32'h0, 1'b0);
    push_wr(c0 + 2, 14'h1, 32'h7, 32'h7);
    push_wr(c0 + 3, 14'h0, 32'h7, 32'h0);
    push_wr(c0 + 4, 14'h6, 32'hFFFF_FFFF, 32'h1C00_0100);
    push_wr(c0 + 5, 14'h5, 32'h7FFF_0000, 32'h000B_0000);
    push_flush(c0 + 7, 32'h1C00_8000);
    #1;
    check("ex_cyc0_gnt", {31'b0, wb_csr_gnt}, 0);
    @(posedge clk); #1;
    idle_inputs();
    check("ex_busy", {31'b0, busy}, 1);
    wait_idle("ex");
    check("ex_prmd", mem[1], 32'h7);
    check("ex_crmd_plvie", mem[0] & 32'h7, 32'h0);
    check("ex_era", mem[6], 32'h1C00_0100);
    check("ex_ecode", {26'b0, mem[5][21:16]}, 32'hB);
    check("ex_badv_untouched", mem[7], 32'hDEAD_BEEF);

    // ALE with BADV, nonzero esubcode
    mem[0] = 32'h0000_001B;
    c0 = cyc;
    drive_ex(6'h9, 9'h1, 32'h1C00_0200, 32'h0000_0003, 1'b1);
    push_wr(c0 + 2, 14'h1, 32'h7, 32'h3);
    push_wr(c0 + 3, 14'h0, 32'h7, 32'h0);
    push_wr(c0 + 4, 14'h6, 32'hFFFF_FFFF, 32'h1C00_0200);
    push_wr(c0 + 5, 14'h5, 32'h7FFF_0000, 32'h0049_0000);
    push_wr(c0 + 6, 14'h7, 32'hFFFF_FFFF, 32'h0000_0003);
    push_flush(c0 + 8, 32'h1C00_8000);
    @(posedge clk); #1;
    idle_inputs();
    wait_idle("ale");
    check("ale_badv", mem[7], 32'h3);
    check("ale_crmd", mem[0], 32'h18);

    // ertn restores CRMD from PRMD and jumps to ERA
    mem[1] = 32'h5;
    mem[6] = 32'h1C00_0104;
    c0 = cyc;
    ertn_req = 1;
    push_wr(c0 + 2, 14'h0, 32'h7, 32'h5);
    push_flush(c0 + 4, 32'h1C00_0104);
    @(posedge clk); #1;
    idle_inputs();
    wait_idle("ertn");
    check("ertn_crmd_plvie", mem[0] & 32'h7, 32'h5);

    // all three requests at once: exception wins, WB write dropped
    c0 = cyc;
    drive_ex(6'h1, 9'h0, 32'h1C00_0300, 32'h0, 1'b0);
    ertn_req = 1;
    wb_csr_req = 1; wb_csr_we = 1; wb_csr_num = 14'h30; wb_csr_wmask = 32'hFFFF_FFFF; wb_csr_wvalue = 32'h5555;
    push_wr(c0 + 2, 14'h1, 32'h7, 32'h5);
    push_wr(c0 + 3, 14'h0, 32'h7, 32'h0);
    push_wr(c0 + 4, 14'h6, 32'hFFFF_FFFF, 32'h1C00_0300);
    push_wr(c0 + 5, 14'h5, 32'h7FFF_0000, 32'h0001_0000);
    push_flush(c0 + 7, 32'h1C00_8000);
    #1;
    check("prio_gnt", {31'b0, wb_csr_gnt}, 0);
    @(posedge clk); #1;
    idle_inputs();
    wait_idle("prio");
    check("prio_mem30", mem[48], 32'h1234);

    // reset while in EX_WR_ESTAT: no ESTAT write, no flush
    c0 = cyc;
    drive_ex(6'h3, 9'h0, 32'h1C00_0400, 32'h0, 1'b0);
    push_wr(c0 + 2, 14'h1, 32'h7, 32'h0);
    push_wr(c0 + 3, 14'h0, 32'h7, 32'h0);
    push_wr(c0 + 4, 14'h6, 32'hFFFF_FFFF, 32'h1C00_0400);
    @(posedge clk); #1;
    idle_inputs();
    repeat (4) @(posedge clk);
    #1;
    resetn = 0;
    @(negedge clk);
    #1;
    check("rstmid_busy", {31'b0, busy}, 0);
    check("rstmid_csr_we", {31'b0, csr_we}, 0);
    @(posedge clk); #1;
    resetn = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      check("rstmid_no_flush", {31'b0, flush_valid}, 0);
    end
    check("rstmid_queue_empty", exp_q.size(), 0);
    check("rstmid_era_kept", mem[6], 32'h1C00_0400);
    check("rstmid_estat_untouched", mem[5], 32'h0001_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
